// File: rtl/branch_target_predictor.sv
// Fetch-stage branch predictor: direct-mapped tagged BTB with saturating counters and a one-deep decode slot.
// Optional statistics counters are built only when BTP_STATS_EN is defined.
module branch_target_predictor #(
  parameter int PC_W    = 8,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic [PC_W-1:0]   fetch_pc_plus1,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_next_pc,
  input  logic              dec_valid,
  input  logic              dec_branch,
  input  logic              dec_taken,
  input  logic [PC_W-1:0]   dec_target,
  output logic              mispredict,
  output logic [PC_W-1:0]   corrected_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_MIN  = '0;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  logic [ENTRIES-1:0] tbl_valid;
  logic [TAG_W-1:0]   tbl_tag    [ENTRIES];
  logic [PC_W-1:0]    tbl_target [ENTRIES];
  logic [CTR_W-1:0]   tbl_ctr    [ENTRIES];

  logic            s_valid;
  logic [PC_W-1:0] s_pc;
  logic [PC_W-1:0] s_pc1;
  logic            s_pred;
  logic [PC_W-1:0] s_tgt;

  logic [IDX_W-1:0] f_idx, s_idx;
  logic [TAG_W-1:0] f_tag, s_tag;
  logic             f_hit, s_hit;
  logic             resolve, train, alias_kill;

  assign f_idx = fetch_pc[IDX_W-1:0];
  assign f_tag = fetch_pc[PC_W-1:IDX_W];
  assign s_idx = s_pc[IDX_W-1:0];
  assign s_tag = s_pc[PC_W-1:IDX_W];

  // Lookups read the registered table, so a write in progress is not visible until the next edge.
  assign f_hit        = tbl_valid[f_idx] && (tbl_tag[f_idx] == f_tag);
  assign pred_taken   = f_hit && tbl_ctr[f_idx][CTR_W-1];
  assign pred_next_pc = pred_taken ? tbl_target[f_idx] : fetch_pc_plus1;

  assign s_hit   = tbl_valid[s_idx] && (tbl_tag[s_idx] == s_tag);
  assign resolve = dec_valid && s_valid;
  assign train   = resolve && dec_branch;

  // NOTE: every output of a combinational block is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    mispredict   = 1'b0;
    corrected_pc = '0;
    alias_kill   = 1'b0;
    if (resolve) begin
      if (dec_branch) begin
        if (dec_taken && (!s_pred || (s_tgt != dec_target))) begin
          mispredict   = 1'b1;
          corrected_pc = dec_target;
        end else if (!dec_taken && s_pred) begin
          mispredict   = 1'b1;
          corrected_pc = s_pc1;
        end
      end else if (s_pred) begin
        // A non-branch hit a taken entry through index/tag aliasing: undo the redirect and drop the entry.
        mispredict   = 1'b1;
        corrected_pc = s_pc1;
        alias_kill   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_pc    <= '0;
      s_pc1   <= '0;
      s_pred  <= 1'b0;
      s_tgt   <= '0;
    end else if (fetch_valid) begin
      s_valid <= 1'b1;
      s_pc    <= fetch_pc;
      s_pc1   <= fetch_pc_plus1;
      s_pred  <= pred_taken;
      s_tgt   <= pred_next_pc;
    end else if (mispredict) begin
      s_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_valid <= '0;
    end else if (train && (s_hit || dec_taken)) begin
      tbl_valid[s_idx] <= 1'b1;
    end else if (alias_kill) begin
      tbl_valid[s_idx] <= 1'b0;
    end
  end

  // NOTE: tag/target/counter storage is not reset; the valid bits alone make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (train) begin
      if (s_hit) begin
        if (dec_taken) begin
          tbl_target[s_idx] <= dec_target;
          if (tbl_ctr[s_idx] != CTR_MAX) tbl_ctr[s_idx] <= tbl_ctr[s_idx] + CTR_W'(1);
        end else if (tbl_ctr[s_idx] != CTR_MIN) begin
          tbl_ctr[s_idx] <= tbl_ctr[s_idx] - CTR_W'(1);
        end
      end else if (dec_taken) begin
        tbl_tag[s_idx]    <= s_tag;
        tbl_target[s_idx] <= dec_target;
        tbl_ctr[s_idx]    <= CTR_WEAK;
      end
    end
  end

`ifdef BTP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (train && (stat_branches != '1)) stat_branches <= stat_branches + STAT_W'(1);
      if (mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised fetch-stage branch predictor for the 5-stage pipelined core, replacing the fixed single-scheme prediction unit. It holds a direct-mapped, tagged branch target buffer (BTB) with per-entry saturating counters, so fetch can redirect to a taken branch target before the instruction is decoded. A one-deep decode slot records each fetched prediction. The decode-stage branch comparator resolves that prediction one cycle later, and the block then raises a mispredict with the corrected PC and trains the table.

## Interface
Parameters:
- PC_W, 8, program-counter width in bits.
- ENTRIES, 16, BTB entries; power of two, 2 ≤ ENTRIES < 2^PC_W.
- CTR_W, 2, saturating counter width; 1..4.
- STAT_W, 16, statistics counter width (see Configuration).

Ports:
- clk, in, 1, clock, rising-edge.
- rst, in, 1, reset; asynchronous, active-high.
- fetch_valid, in, 1, fetch advancing this cycle (PC/IF-ID enable).
- fetch_pc, in, PC_W, PC being fetched.
- fetch_pc_plus1, in, PC_W, fetch_pc + 1.
- pred_taken, out, 1, predicted taken (combinational).
- pred_next_pc, out, PC_W, BTB target if pred_taken, else fetch_pc_plus1.
- dec_valid, in, 1, decode holds a real instruction, resolved this cycle; 0 for bubbles and stall cycles.
- dec_branch, in, 1, decode instruction is a conditional branch.
- dec_taken, in, 1, branch outcome from decode comparator.
- dec_target, in, PC_W, computed branch target.
- mispredict, out, 1, redirect fetch and flush IF/ID (combinational).
- corrected_pc, out, PC_W, redirect PC, valid when mispredict=1.
- stat_branches, out, STAT_W, resolved-branch count.
- stat_mispredicts, out, STAT_W, mispredict count.

## Operation
- IDX_W = clog2(ENTRIES). The table index is fetch_pc[IDX_W-1:0] and the tag is fetch_pc[PC_W-1:IDX_W].
- Each entry holds valid, tag, target[PC_W], and ctr[CTR_W].
- Lookup is combinational: hit = valid & tag match, and pred_taken = hit & ctr[CTR_W-1].
- Decode slot registers: s_valid, s_pc, s_pc1, s_pred, s_tgt.
  - Loaded with the current lookup when fetch_valid=1.
  - Held when fetch_valid=0.
- Resolution happens only when dec_valid=1 and s_valid=1:
  - Branch, actual taken and (s_pred=0 or s_tgt≠dec_target): mispredict, corrected_pc = dec_target.
  - Branch, actual not taken and s_pred=1: mispredict, corrected_pc = s_pc1.
  - Non-branch with s_pred=1 (alias): mispredict, corrected_pc = s_pc1, and the entry at s_pc is invalidated.
  - Otherwise mispredict=0.
- Training on a resolved branch, at index/tag of s_pc:
  - Hit: ctr saturating +1 if taken, −1 if not; target ← dec_target if taken.
  - Miss and taken: allocate with valid=1, tag, target=dec_target, ctr = 2^(CTR_W-1) (weakly taken).
  - Miss and not taken: no write.
- On a mispredict, s_valid is cleared at the next edge unless fetch_valid=1 loads it.
- The wrong-path instruction fetched in the mispredict cycle is discarded by the IF/ID flush. The integrator drives dec_valid=0 for it.

## Timing
- Reset (async, immediate):
  - All entry valid bits = 0 and s_valid = 0.
  - Slot registers = 0.
  - Statistics = 0.
- Outputs during reset: pred_taken=0, pred_next_pc=fetch_pc_plus1, mispredict=0, corrected_pc=0.
- Prediction latency is 0 cycles; resolution occurs 1 cycle after fetch, and mispredict is combinational in that cycle.
- Table writes take effect at the clock edge ending the resolve cycle.
- A same-cycle lookup of the index being written sees the old contents.
- A mispredict penalty is 1 bubble.
- Reset asserted mid-operation discards the slot and all training; no mispredict is raised.

## Configuration
- BTP_STATS_EN:
  - Defined: stat_branches increments on every resolved branch and stat_mispredicts on every mispredict. Both saturate at 2^STAT_W−1 and reset to 0.
  - Undefined: no counter registers are built, and both outputs are tied to 0.

## Test plan
- Reset, then fetch_pc=0x10 with an empty table -> pred_taken=0 and pred_next_pc=0x11.
- Fetch 0x10, then resolve as a taken branch with target 0x30 -> mispredict=1 and corrected_pc=0x30. The entry is allocated with ctr=2; refetching 0x10 gives pred_taken=1 and pred_next_pc=0x30.
- Entry at 0x10 with ctr=2, resolve not-taken -> mispredict=1 and corrected_pc=0x11, ctr becomes 1; next fetch of 0x10 gives pred_taken=0. Two taken resolves take ctr to 3 and hold it there on a third.
- Alias: 0x20 is trained taken (ENTRIES=16). Fetching 0x30 misses on tag with no prediction. Forcing a predicted-taken non-branch in the slot -> mispredict with corrected_pc=s_pc1 and the entry invalidated.
- Hold fetch_valid=0 for 3 cycles with dec_valid=0 -> slot unchanged, no table writes, and the later resolve uses the original slot.
- With BTP_STATS_EN: 5 branches including 2 mispredicts -> stat_branches=5 and stat_mispredicts=2. Asserting rst mid-sequence zeroes both asynchronously.
